// File: rtl/param_updown_counter.sv
// Up/down counter with a runtime-programmable terminal value,
// wrap or saturate policy, clamped loads and one-cycle event pulses.
module param_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_RST = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             mode,
    input  logic             sat,
    input  logic             cfg_wr,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             load_err_nxt;
    logic             at_top;
    logic             at_zero;

    assign at_top  = (count >= lim);
    assign at_zero = (count == '0);
    assign tc      = (mode && at_top) || (!mode && at_zero);

    // Next-state decision always uses the lim in force before this edge.
    always_comb begin
        count_nxt    = count;
        wrap_nxt     = 1'b0;
        load_err_nxt = 1'b0;
        if (load) begin
            if (din > lim) begin
                count_nxt    = lim;
                load_err_nxt = 1'b1;
            end else begin
                count_nxt = din;
            end
        end else if (en) begin
            if (mode) begin
                if (!at_top) begin
                    count_nxt = count + WIDTH'(1);
                end else if (sat) begin
                    count_nxt = lim;
                end else begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (count > lim) begin
                    count_nxt = lim;
                end else if (!at_zero) begin
                    count_nxt = count - WIDTH'(1);
                end else if (!sat) begin
                    count_nxt = lim;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
            lim      <= WIDTH'(MAX_RST);
        end else begin
            count    <= count_nxt;
            wrap     <= wrap_nxt;
            load_err <= load_err_nxt;
            if (cfg_wr) begin
                lim <= max_val;
            end
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter: a 4-bit default instance
// and an 8-bit instance share stimulus and are checked every cycle.
module tb_param_updown_counter;

    logic        clock = 1'b0;
    logic        reset, en, load, mode, sat, cfg_wr;
    logic [15:0] din, max_val;

    logic [3:0]  c4;
    logic        t4, w4, l4;
    logic [7:0]  c8;
    logic        t8, w8, l8;

    always #5 clock = ~clock;

    param_updown_counter u4 (
        .clock(clock), .reset(reset), .en(en), .load(load),
        .din(din[3:0]), .mode(mode), .sat(sat), .cfg_wr(cfg_wr),
        .max_val(max_val[3:0]), .count(c4), .tc(t4), .wrap(w4),
        .load_err(l4)
    );

    param_updown_counter #(.WIDTH(8), .MAX_RST(255)) u8 (
        .clock(clock), .reset(reset), .en(en), .load(load),
        .din(din[7:0]), .mode(mode), .sat(sat), .cfg_wr(cfg_wr),
        .max_val(max_val[7:0]), .count(c8), .tc(t8), .wrap(w8),
        .load_err(l8)
    );

    typedef struct packed {
        logic [3:0] c4;
        logic       w4, l4, t4;
        logic [7:0] c8;
        logic       w8, l8, t8;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_c4 = '0, m_l4 = 16'd11, m_c8 = '0, m_l8 = 16'd255;
    int          checks = 0;
    int          errors = 0;

    task automatic model_step(input int width, input logic [15:0] rst_lim,
                              inout logic [15:0] c, inout logic [15:0] lim,
                              output logic w, output logic le);
        logic [15:0] mask, d, mv, old;
        mask = 16'((32'd1 << width) - 1);
        d    = din & mask;
        mv   = max_val & mask;
        w    = 1'b0;
        le   = 1'b0;
        if (reset) begin
            c   = '0;
            lim = rst_lim;
        end else begin
            old = lim;
            if (cfg_wr) lim = mv;
            if (load) begin
                if (d > old) begin
                    c  = old;
                    le = 1'b1;
                end else begin
                    c = d;
                end
            end else if (en) begin
                if (mode) begin
                    if (c < old) c = c + 16'd1;
                    else if (sat) c = old;
                    else begin
                        c = '0;
                        w = 1'b1;
                    end
                end else begin
                    if (c > old) c = old;
                    else if (c != 0) c = c - 16'd1;
                    else if (!sat) begin
                        c = old;
                        w = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic drive();
        exp_t e;
        logic w, le;
        model_step(4, 16'd11, m_c4, m_l4, w, le);
        e.c4 = m_c4[3:0];
        e.w4 = w;
        e.l4 = le;
        e.t4 = (mode && m_c4 >= m_l4) || (!mode && m_c4 == 0);
        model_step(8, 16'd255, m_c8, m_l8, w, le);
        e.c8 = m_c8[7:0];
        e.w8 = w;
        e.l8 = le;
        e.t8 = (mode && m_c8 >= m_l8) || (!mode && m_c8 == 0);
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic r, ld, e_, m, s, cw,
                          input logic [15:0] d, mv);
        reset   = r;
        load    = ld;
        en      = e_;
        mode    = m;
        sat     = s;
        cfg_wr  = cw;
        din     = d;
        max_val = mv;
    endtask

    task automatic test_reset();
        exp_t e;
        set_in(1, 1, 1, 0, 0, 1, 16'd5, 16'd3);
        drive();
        e = q.pop_front();
        checks++;
        if ({c4, w4, l4, t4, c8, w8, l8, t8} !== e) begin
            errors++;
            $display("FAIL reset: got %h want %h",
                     {c4, w4, l4, t4, c8, w8, l8, t8}, e);
        end
        checks++;
        if (c4 !== 4'd0 || w4 !== 1'b0 || l4 !== 1'b0 || t4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_const: count=%0d wrap=%b lerr=%b tc=%b want 0 0 0 1",
                     c4, w4, l4, t4);
        end
    endtask

    task automatic test_up_wrap();
        exp_t e;
        logic [3:0] want;
        set_in(1, 0, 0, 1, 0, 0, 0, 0);
        drive();
        void'(q.pop_front());
        for (int k = 1; k <= 13; k++) begin
            set_in(0, 0, 1, 1, 0, 0, 0, 0);
            drive();
            e = q.pop_front();
            checks++;
            if ({c4, w4, l4, t4, c8, w8, l8, t8} !== e) begin
                errors++;
                $display("FAIL up_wrap k=%0d: got %h want %h", k,
                         {c4, w4, l4, t4, c8, w8, l8, t8}, e);
            end
            want = 4'(k % 12);
            checks++;
            if (c4 !== want || w4 !== (k == 12) || t4 !== (want == 4'd11)) begin
                errors++;
                $display("FAIL up_seq k=%0d: count=%0d wrap=%b tc=%b want count=%0d",
                         k, c4, w4, t4, want);
            end
        end
    endtask

    task automatic test_down();
        exp_t e;
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        drive();
        void'(q.pop_front());
        for (int k = 0; k < 18; k++) begin
            set_in(0, 0, 1, 0, (k >= 3), 0, 0, 0);
            drive();
            e = q.pop_front();
            checks++;
            if ({c4, w4, l4, t4, c8, w8, l8, t8} !== e) begin
                errors++;
                $display("FAIL down k=%0d: got %h want %h", k,
                         {c4, w4, l4, t4, c8, w8, l8, t8}, e);
            end
            if (k == 0) begin
                checks++;
                if (c4 !== 4'd11 || w4 !== 1'b1) begin
                    errors++;
                    $display("FAIL down_wrap: count=%0d wrap=%b want 11 1", c4, w4);
                end
            end
        end
        checks++;
        if (c4 !== 4'd0 || w4 !== 1'b0 || t4 !== 1'b1) begin
            errors++;
            $display("FAIL down_sat: count=%0d wrap=%b tc=%b want 0 0 1", c4, w4, t4);
        end
    endtask

    task automatic test_load();
        exp_t e;
        set_in(1, 0, 0, 1, 0, 0, 0, 0);
        drive();
        void'(q.pop_front());
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: set_in(0, 1, 1, 1, 0, 0, 16'd14, 0);
                1: set_in(0, 1, 0, 1, 0, 0, 16'd5, 0);
                2: set_in(0, 0, 0, 1, 0, 0, 16'd9, 0);
                default: set_in(0, 1, 1, 0, 0, 0, 16'd11, 0);
            endcase
            drive();
            e = q.pop_front();
            checks++;
            if ({c4, w4, l4, t4, c8, w8, l8, t8} !== e) begin
                errors++;
                $display("FAIL load k=%0d: got %h want %h", k,
                         {c4, w4, l4, t4, c8, w8, l8, t8}, e);
            end
            if (k == 0) begin
                checks++;
                if (c4 !== 4'd11 || l4 !== 1'b1) begin
                    errors++;
                    $display("FAIL load_clamp: count=%0d lerr=%b want 11 1", c4, l4);
                end
            end
            if (k == 1) begin
                checks++;
                if (c4 !== 4'd5 || l4 !== 1'b0) begin
                    errors++;
                    $display("FAIL load_noen: count=%0d lerr=%b want 5 0", c4, l4);
                end
            end
        end
    endtask

    task automatic test_cfg();
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0, 4: set_in(1, 0, 0, 1, 0, 0, 0, 0);
                1, 5: set_in(0, 1, 0, 1, 0, 0, 16'd9, 0);
                2:    set_in(0, 0, 1, 1, 0, 1, 0, 16'd6);
                3:    set_in(0, 0, 1, 1, 0, 0, 0, 0);
                6:    set_in(0, 0, 1, 0, 0, 1, 0, 16'd6);
                default: set_in(0, 0, 1, 0, 0, 0, 0, 0);
            endcase
            drive();
            e = q.pop_front();
            checks++;
            if ({c4, w4, l4, t4, c8, w8, l8, t8} !== e) begin
                errors++;
                $display("FAIL cfg k=%0d: got %h want %h", k,
                         {c4, w4, l4, t4, c8, w8, l8, t8}, e);
            end
            if (k == 2 || k == 3 || k == 7) begin
                checks++;
                if (c4 !== (k == 2 ? 4'd10 : k == 3 ? 4'd0 : 4'd6) ||
                    w4 !== (k == 3)) begin
                    errors++;
                    $display("FAIL cfg_const k=%0d: count=%0d wrap=%b", k, c4, w4);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int k = 0; k < 15; k++) begin
            case (k)
                0: set_in(1, 0, 0, 1, 0, 0, 0, 0);
                1: set_in(0, 1, 0, 1, 0, 0, 16'd7, 0);
                2: set_in(1, 1, 1, 1, 0, 1, 16'd3, 16'd3);
                default: set_in(0, 0, 1, 1, 0, 0, 0, 0);
            endcase
            drive();
            e = q.pop_front();
            checks++;
            if ({c4, w4, l4, t4, c8, w8, l8, t8} !== e) begin
                errors++;
                $display("FAIL reset_mid k=%0d: got %h want %h", k,
                         {c4, w4, l4, t4, c8, w8, l8, t8}, e);
            end
        end
        checks++;
        if (c4 !== 4'd0 || w4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_lim: count=%0d wrap=%b want 0 1", c4, w4);
        end
    endtask

    task automatic test_width8();
        exp_t e;
        for (int k = 0; k < 12; k++) begin
            case (k)
                0: set_in(1, 0, 0, 1, 0, 0, 0, 0);
                1, 3: set_in(0, 1, 0, 1, 0, 0, 16'd255, 0);
                2: set_in(0, 0, 1, 1, 0, 0, 0, 0);
                4, 5: set_in(0, 0, 1, 1, 1, 0, 0, 0);
                6: set_in(0, 0, 1, 1, 0, 1, 0, 16'd0);
                7, 8: set_in(0, 0, 1, 1, 0, 0, 0, 0);
                default: set_in(0, 0, 1, 0, 0, 0, 0, 0);
            endcase
            drive();
            e = q.pop_front();
            checks++;
            if ({c4, w4, l4, t4, c8, w8, l8, t8} !== e) begin
                errors++;
                $display("FAIL width8 k=%0d: got %h want %h", k,
                         {c4, w4, l4, t4, c8, w8, l8, t8}, e);
            end
            if (k == 2 || k == 5 || k >= 7) begin
                checks++;
                if (c8 !== (k == 5 ? 8'd255 : 8'd0) || w8 !== (k != 5)) begin
                    errors++;
                    $display("FAIL width8_const k=%0d: count=%0d wrap=%b", k, c8, w8);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        drive();
        void'(q.pop_front());
        for (int k = 0; k < 300; k++) begin
            set_in(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 9) == 0), 16'($urandom),
                   16'($urandom_range(0, 20)));
            drive();
            e = q.pop_front();
            checks++;
            if ({c4, w4, l4, t4, c8, w8, l8, t8} !== e) begin
                errors++;
                $display("FAIL random k=%0d: got %h want %h", k,
                         {c4, w4, l4, t4, c8, w8, l8, t8}, e);
            end
        end
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        test_reset();
        test_up_wrap();
        test_down();
        test_load();
        test_cfg();
        test_reset_mid();
        test_width8();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
